// File: rtl/mips.sv
// Five-stage MIPS-subset pipeline (F/D/E/M/W) with forwarding and interlocks,
// plus a minimal CP0 supporting a single external interrupt and eret.
module mips (
   input  logic        clk,
   input  logic        reset,
   input  logic        interrupt,
   output logic [31:0] macroscopic_pc,
   output logic [31:0] i_inst_addr,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] m_data_addr,
   input  logic [31:0] m_data_rdata,
   output logic [31:0] m_data_wdata,
   output logic [3:0]  m_data_byteen,
   output logic [31:0] m_inst_addr,
   output logic        w_grf_we,
   output logic [4:0]  w_grf_addr,
   output logic [31:0] w_grf_wdata,
   output logic [31:0] w_inst_addr
);
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
   localparam logic [31:0] SR_MASK  = 32'h0000_FC03;

   typedef enum logic [1:0] {SRC_ALU, SRC_MEM, SRC_CP0, SRC_LINK} src_e;
   typedef struct packed {
      logic [4:0] dst;
      src_e       src;
      logic       rs_d, rt_d, rs_e, rt_e;
      logic       brj, sw, mtc0, eret;
   } dec_t;

   // rs_d/rt_d: operand needed in D; rs_e/rt_e: operand needed from E onward
   function automatic dec_t decode(input logic [31:0] ir);
      dec_t d;
      d = '0;
      d.src = SRC_ALU;
      case (ir[31:26])
         6'h00: begin
            case (ir[5:0])
               6'h21, 6'h23, 6'h24, 6'h25, 6'h2a: begin
                  d.dst = ir[15:11]; d.rs_e = 1'b1; d.rt_e = 1'b1;
               end
               6'h08: begin d.rs_d = 1'b1; d.brj = 1'b1; end
               default: ;
            endcase
         end
         6'h09, 6'h0d: begin d.dst = ir[20:16]; d.rs_e = 1'b1; end
         6'h0f: d.dst = ir[20:16];
         6'h23: begin d.dst = ir[20:16]; d.rs_e = 1'b1; d.src = SRC_MEM; end
         6'h2b: begin d.rs_e = 1'b1; d.rt_e = 1'b1; d.sw = 1'b1; end
         6'h04, 6'h05: begin d.rs_d = 1'b1; d.rt_d = 1'b1; d.brj = 1'b1; end
         6'h02: d.brj = 1'b1;
         6'h03: begin d.dst = 5'd31; d.src = SRC_LINK; d.brj = 1'b1; end
         6'h10: begin
            if (ir[25:21] == 5'h00) begin d.dst = ir[20:16]; d.src = SRC_CP0; end
            else if (ir[25:21] == 5'h04) begin d.rt_e = 1'b1; d.mtc0 = 1'b1; end
            else if (ir == 32'h4200_0018) d.eret = 1'b1;
         end
         default: ;
      endcase
      return d;
   endfunction

   function automatic logic dep(input logic use_r, input logic [4:0] r, input logic [4:0] dst);
      return use_r && (r != 5'd0) && (r == dst);
   endfunction

   logic [31:0]      pc_q, d_ir_q, d_pc_q, e_ir_q, e_pc_q, m_ir_q, m_pc_q, m_res_q, m_rt_q;
   logic             d_bd_q, e_bd_q, m_bd_q;
   logic [1:0][31:0] e_v_q;
   logic             w_we_q;
   logic [4:0]       w_dst_q;
   logic [31:0]      w_data_q, w_pc_q;
   logic [31:0]      rf_q [32];
   logic [31:0]      sr_q, epc_q;
   logic             bd_q, ip_q;
   logic [4:0]       exc_q;

   dec_t dd, de, dm;
   assign dd = decode(d_ir_q);
   assign de = decode(e_ir_q);
   assign dm = decode(m_ir_q);

   logic e_late, m_late, irq, stall;
   assign e_late = (de.src == SRC_MEM) || (de.src == SRC_CP0);
   assign m_late = (dm.src == SRC_MEM) || (dm.src == SRC_CP0);
   assign irq    = interrupt & sr_q[10] & sr_q[0] & ~sr_q[1];

   // D-stage operand read: E (link only) > M (ALU/link) > W > GRF
   logic [1:0][4:0]  d_r, e_r;
   logic [1:0][31:0] d_val, e_fv;
   assign d_r = {d_ir_q[20:16], d_ir_q[25:21]};
   assign e_r = {e_ir_q[20:16], e_ir_q[25:21]};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         if (d_r[i] == 5'd0)                              d_val[i] = '0;
         else if (de.dst == d_r[i] && de.src == SRC_LINK) d_val[i] = e_pc_q + 32'd8;
         else if (dm.dst == d_r[i] && !m_late)            d_val[i] = m_res_q;
         else if (w_we_q && w_dst_q == d_r[i])            d_val[i] = w_data_q;
         else                                             d_val[i] = rf_q[d_r[i]];
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         if (e_r[i] == 5'd0)                        e_fv[i] = '0;
         else if (dm.dst == e_r[i] && !m_late)      e_fv[i] = m_res_q;
         else if (w_we_q && w_dst_q == e_r[i])      e_fv[i] = w_data_q;
         else                                       e_fv[i] = e_v_q[i];
      end
   end

   assign stall = (dep(dd.rs_d, d_r[0], de.dst) && de.src != SRC_LINK)
               || (dep(dd.rt_d, d_r[1], de.dst) && de.src != SRC_LINK)
               || (dep(dd.rs_d, d_r[0], dm.dst) && m_late)
               || (dep(dd.rt_d, d_r[1], dm.dst) && m_late)
               || (dep(dd.rs_e, d_r[0], de.dst) && e_late)
               || (dep(dd.rt_e, d_r[1], de.dst) && e_late);

   // E-stage ALU
   logic [31:0] e_imm, e_res;
   assign e_imm = {{16{e_ir_q[15]}}, e_ir_q[15:0]};
   always_comb begin
      e_res = e_fv[0] + e_imm;
      case (e_ir_q[31:26])
         6'h00: begin
            case (e_ir_q[5:0])
               6'h21:   e_res = e_fv[0] + e_fv[1];
               6'h23:   e_res = e_fv[0] - e_fv[1];
               6'h24:   e_res = e_fv[0] & e_fv[1];
               6'h25:   e_res = e_fv[0] | e_fv[1];
               6'h2a:   e_res = {31'd0, $signed(e_fv[0]) < $signed(e_fv[1])};
               default: ;
            endcase
         end
         6'h0d:   e_res = e_fv[0] | {16'd0, e_ir_q[15:0]};
         6'h0f:   e_res = {e_ir_q[15:0], 16'd0};
         6'h03:   e_res = e_pc_q + 32'd8;
         default: ;
      endcase
   end

   // M stage: store data, CP0 read, writeback value
   logic [31:0] m_wd, cp0_rd, m_val, epc_fwd;
   assign m_wd = (w_we_q && w_dst_q == m_ir_q[20:16]) ? w_data_q : m_rt_q;
   always_comb begin
      case (m_ir_q[15:11])
         5'd12:   cp0_rd = sr_q;
         5'd13:   cp0_rd = {bd_q, 20'd0, ip_q, 3'd0, exc_q, 2'd0};
         5'd14:   cp0_rd = epc_q;
         default: cp0_rd = '0;
      endcase
   end
   assign m_val = (dm.src == SRC_MEM) ? m_data_rdata :
                  (dm.src == SRC_CP0) ? cp0_rd : m_res_q;

   // eret sees an EPC write that is still in flight ahead of it
   assign epc_fwd = (de.mtc0 && e_ir_q[15:11] == 5'd14) ? e_fv[1] :
                    (dm.mtc0 && m_ir_q[15:11] == 5'd14) ? m_wd : epc_q;

   logic [31:0] d_imm, npc;
   logic        taken;
   assign d_imm = {{16{d_ir_q[15]}}, d_ir_q[15:0]};
   assign taken = (d_ir_q[31:26] == 6'h04 && d_val[0] == d_val[1])
               || (d_ir_q[31:26] == 6'h05 && d_val[0] != d_val[1]);
   always_comb begin
      npc = pc_q + 32'd4;
      if (dd.eret)                                              npc = epc_fwd;
      else if (taken)                                           npc = d_pc_q + 32'd4 + {d_imm[29:0], 2'b00};
      else if (d_ir_q[31:26] == 6'h02 || d_ir_q[31:26] == 6'h03) npc = {d_pc_q[31:28], d_ir_q[25:0], 2'b00};
      else if (dd.brj && d_ir_q[31:26] == 6'h00)                npc = d_val[0];
   end

   always_ff @(posedge clk) begin
      if (reset || irq) begin
         pc_q   <= reset ? RESET_PC : EXC_VEC;
         d_ir_q <= '0; d_pc_q <= reset ? '0 : EXC_VEC; d_bd_q <= 1'b0;
         e_ir_q <= '0; e_pc_q <= reset ? '0 : EXC_VEC; e_bd_q <= 1'b0; e_v_q <= '0;
         m_ir_q <= '0; m_pc_q <= reset ? '0 : EXC_VEC; m_bd_q <= 1'b0;
         m_res_q <= '0; m_rt_q <= '0;
         w_we_q <= 1'b0; w_dst_q <= '0; w_data_q <= '0; w_pc_q <= reset ? '0 : EXC_VEC;
      end else begin
         w_we_q   <= dm.dst != 5'd0;
         w_dst_q  <= dm.dst;
         w_data_q <= m_val;
         w_pc_q   <= m_pc_q;
         m_ir_q   <= e_ir_q; m_pc_q <= e_pc_q; m_bd_q <= e_bd_q;
         m_res_q  <= e_res;  m_rt_q <= e_fv[1];
         if (stall) begin
            e_ir_q <= '0; e_pc_q <= d_pc_q; e_bd_q <= d_bd_q; e_v_q <= '0;
         end else begin
            e_ir_q <= d_ir_q; e_pc_q <= d_pc_q; e_bd_q <= d_bd_q; e_v_q <= d_val;
            pc_q   <= npc;
            if (dd.eret) begin
               d_ir_q <= '0; d_pc_q <= npc; d_bd_q <= 1'b0;
            end else begin
               d_ir_q <= i_inst_rdata; d_pc_q <= pc_q; d_bd_q <= dd.brj;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (w_we_q) begin
         rf_q[w_dst_q] <= w_data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q <= '0; epc_q <= '0; bd_q <= 1'b0; exc_q <= '0; ip_q <= 1'b0;
      end else begin
         ip_q <= interrupt;
         if (irq) begin
            epc_q   <= m_bd_q ? m_pc_q - 32'd4 : m_pc_q;
            bd_q    <= m_bd_q;
            exc_q   <= '0;
            sr_q[1] <= 1'b1;
         end else begin
            if (dm.mtc0 && m_ir_q[15:11] == 5'd12) sr_q  <= m_wd & SR_MASK;
            if (dm.mtc0 && m_ir_q[15:11] == 5'd14) epc_q <= m_wd;
            if (dm.eret) sr_q[1] <= 1'b0;
         end
      end
   end

   assign i_inst_addr    = pc_q;
   assign macroscopic_pc = m_pc_q;
   assign m_inst_addr    = m_pc_q;
   assign m_data_addr    = m_res_q;
   assign m_data_wdata   = m_wd;
   assign m_data_byteen  = (dm.sw && !irq) ? 4'hf : 4'h0;
   assign w_grf_we       = w_we_q;
   assign w_grf_addr     = w_dst_q;
   assign w_grf_wdata    = w_data_q;
   assign w_inst_addr    = w_pc_q;
endmodule

// File: tb/tb_mips.sv
// Directed program for mips: ALU chain, sw/lw, branches, jal/jr, hazards,
// and an interrupt taken on a store followed by eret back to it.
module tb_mips;
   logic        clk = 1'b0, reset = 1'b1, interrupt = 1'b0;
   logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
   logic [31:0] m_data_wdata, m_inst_addr, w_grf_wdata, w_inst_addr;
   logic [3:0]  m_data_byteen;
   logic        w_grf_we;
   logic [4:0]  w_grf_addr;

   always #5 clk = ~clk;

   mips dut (
      .clk(clk), .reset(reset), .interrupt(interrupt),
      .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
      .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
      .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .w_grf_we(w_grf_we),
      .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
   );

   logic [31:0] rom  [0:63];
   logic [31:0] hrom [0:3];
   logic [31:0] ram  [0:15];
   assign i_inst_rdata = (i_inst_addr[31:8] == 24'h000030)  ? rom[i_inst_addr[7:2]] :
                         (i_inst_addr[31:4] == 28'h0000418) ? hrom[i_inst_addr[3:2]] : 32'h0;
   assign m_data_rdata = ram[m_data_addr[5:2]];

   typedef struct { logic [4:0] a; logic [31:0] d; logic [31:0] pc; int c; } wr_t;
   typedef struct { logic [31:0] a; logic [31:0] d; } mw_t;
   wr_t wlog[$];
   mw_t mlog[$];
   int  cyc = 0;

   // cycle numbers are relative to the first writeback (ori $1)
   wr_t exp_w [16] = '{
      '{5'd1,  32'h00001234, 32'h3000, 0},  '{5'd2,  32'h56780000, 32'h3004, 1},
      '{5'd3,  32'h56781234, 32'h3008, 2},  '{5'd31, 32'h00003018, 32'h3010, 4},
      '{5'd7,  32'h00000007, 32'h3014, 5},  '{5'd6,  32'h00000001, 32'h3044, 7},
      '{5'd4,  32'h56781234, 32'h3018, 10}, '{5'd5,  32'hACF02468, 32'h301c, 12},
      '{5'd9,  32'h00002468, 32'h3020, 13}, '{5'd10, 32'h0000000a, 32'h3028, 16},
      '{5'd12, 32'h00003060, 32'h3030, 17}, '{5'd13, 32'h0000000d, 32'h3038, 21},
      '{5'd14, 32'h00000401, 32'h3060, 22}, '{5'd15, 32'h00000055, 32'h3068, 24},
      '{5'd20, 32'h00000099, 32'h4180, 29}, '{5'd16, 32'h00000066, 32'h3070, 33}
   };
   mw_t exp_m [2] = '{'{32'h0, 32'h56781234}, '{32'h8, 32'h00000055}};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && m_data_byteen == 4'hf) begin
         ram[m_data_addr[5:2]] <= m_data_wdata;
         mlog.push_back('{m_data_addr, m_data_wdata});
      end
   end

   always @(negedge clk)
      if (!reset && w_grf_we) wlog.push_back('{w_grf_addr, w_grf_wdata, w_inst_addr, cyc});

   int checks = 0, failures = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   initial begin
      logic found;
      for (int i = 0; i < 64; i++) rom[i] = 32'h0;
      for (int i = 0; i < 16; i++) ram[i] = 32'h0;
      ram[1] = 32'h0000_3060;
      rom[0]  = 32'h34011234; rom[1]  = 32'h3c025678; rom[2]  = 32'h00221821; // ori, lui, addu
      rom[3]  = 32'hac030000; rom[4]  = 32'h0c000c10; rom[5]  = 32'h34070007; // sw, jal 3040, ori $7
      rom[6]  = 32'h8c040000; rom[7]  = 32'h00842821; rom[8]  = 32'h00214821; // lw, addu $5, addu $9
      rom[9]  = 32'h15200002; rom[10] = 32'h340a000a; rom[11] = 32'h340b000b; // bne, ori $10, ori $11
      rom[12] = 32'h8c0c0004; rom[13] = 32'h01800008; rom[14] = 32'h340d000d; // lw $12, jr $12, ori $13
      rom[16] = 32'h10000002; rom[17] = 32'h34060001; rom[18] = 32'h34080bad; // beq, ori $6, ori $8
      rom[19] = 32'h03e00008; rom[20] = 32'h00000000;                         // jr $31, nop
      rom[24] = 32'h340e0401; rom[25] = 32'h408e6000; rom[26] = 32'h340f0055; // ori $14, mtc0 SR, ori $15
      rom[27] = 32'hac0f0008; rom[28] = 32'h34100066; rom[29] = 32'h1000ffff; // sw, ori $16, loop
      rom[30] = 32'h00000000;
      hrom[0] = 32'h34140099; hrom[1] = 32'h42000018; hrom[2] = 32'h341500ee; hrom[3] = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.i_inst_addr", i_inst_addr, 32'h3000);
      chk("rst.macroscopic_pc", macroscopic_pc, 32'h0);
      chk("rst.byteen", {28'd0, m_data_byteen}, 32'h0);
      chk("rst.grf_we", {31'd0, w_grf_we}, 32'h0);
      chk("rst.grf_wdata", w_grf_wdata, 32'h0);
      chk("rst.w_inst_addr", w_inst_addr, 32'h0);
      reset = 1'b0;

      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (m_inst_addr == 32'h306c) found = 1'b1;
      end
      chk("irq.sw_reached_m", {31'd0, found}, 32'h1);
      if (found) begin
         chk("irq.byteen_before", {28'd0, m_data_byteen}, 32'hf);
         interrupt = 1'b1;
         #1;
         chk("irq.byteen_cancel", {28'd0, m_data_byteen}, 32'h0);
         chk("irq.macroscopic_pc", macroscopic_pc, 32'h306c);
         @(posedge clk);
         #1;
         interrupt = 1'b0;
         chk("irq.vector", i_inst_addr, 32'h4180);
      end
      repeat (40) @(negedge clk);

      chk("w.count", wlog.size(), 16);
      for (int i = 0; i < 16; i++) begin
         if (i < wlog.size()) begin
            chk($sformatf("w%0d.addr", i), {27'd0, wlog[i].a}, {27'd0, exp_w[i].a});
            chk($sformatf("w%0d.data", i), wlog[i].d, exp_w[i].d);
            chk($sformatf("w%0d.pc", i), wlog[i].pc, exp_w[i].pc);
            chk($sformatf("w%0d.cycle", i), wlog[i].c - wlog[0].c, exp_w[i].c);
         end
      end
      chk("mem.count", mlog.size(), 2);
      for (int i = 0; i < 2; i++) begin
         if (i < mlog.size()) begin
            chk($sformatf("mem%0d.addr", i), mlog[i].a, exp_m[i].a);
            chk($sformatf("mem%0d.data", i), mlog[i].d, exp_m[i].d);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
